fifo_burst_reader: RTL

//   Read-side controller for the fifo block (FIFO_if). On a start command it pops
//   a burst of len words from a show-ahead FIFO and forwards them as a registered

---
 rtl/fifo_burst_reader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a burst of len words from a show-ahead FIFO and
// forwards them as a registered valid/ready stream with last/done markers.
//
// Ports:
//   CLK, nRST      clock (rising edge), asynchronous active-low reset
//   start, len     burst request; sampled only while idle
//   busy, done     busy while streaming or finishing; done is a 1-cycle pulse
//   words_sent     beats accepted downstream in the current burst
//   fifo_dat_out   FIFO head word (show-ahead), fifo_is_empty its empty flag
//   fifo_pop       combinational pop request to the FIFO
//   out_valid, out_ready, out_data, out_last   downstream stream

package fifo_burst_pkg;
    typedef logic [31:0] word_t;
endpackage

module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int MAX_LEN = 16,
    localparam int LW = $clog2(MAX_LEN) + 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] words_sent,
    input  word_t         fifo_dat_out,
    input  logic          fifo_is_empty,
    output logic          fifo_pop,
    output logic          out_valid,
    input  logic          out_ready,
    output word_t         out_data,
    output logic          out_last
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] remaining;
    logic [LW-1:0] len_q;
    logic [LW-1:0] len_eff;
    logic          hs;
    logic          accept;

    // Out-of-range requests are clamped so the counters stay meaningful.
    assign len_eff = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
    assign hs      = out_valid && out_ready;
    assign accept  = (state == IDLE) && start;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        fifo_pop  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len_eff == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                busy = 1'b1;
                // Refill the output register when it is empty or being
                // drained this cycle, which keeps one beat per cycle.
                fifo_pop = (remaining != '0) && !fifo_is_empty &&
                           (!out_valid || out_ready);
                if (hs && out_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            remaining  <= '0;
            len_q      <= '0;
            words_sent <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
        end else begin
            if (accept) begin
                remaining  <= len_eff;
                len_q      <= len_eff;
                words_sent <= '0;
            end
            if (fifo_pop) begin
                out_data  <= fifo_dat_out;
                out_valid <= 1'b1;
                out_last  <= (remaining == LW'(1));
                remaining <= remaining - LW'(1);
            end else if (hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (hs && (words_sent != len_q)) begin
                words_sent <= words_sent + LW'(1);
            end
        end
    end

endmodule
